// File: rtl/config_reg_bank.sv
// Generic synchronous FIFO used for the response queue.
// Latency: data written at an edge is visible at rd_dat the following cycle.
// Backpressure: caller must not push when count == DEPTH; a pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             do_rd;

  assign do_rd  = rd_en && (count != '0);
  assign rd_dat = mem[head];

  // Pointer/count bookkeeping and storage; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_dat;
        tail      <= tail + PW'(1);
      end
      if (do_rd) head <= head + PW'(1);
      if (wr_en && !do_rd)      count <= count + (PW+1)'(1);
      else if (!wr_en && do_rd) count <= count - (PW+1)'(1);
    end
  end

endmodule

// Configuration register bank: val/rdy write/read requests, one response per request.
// Latency: response valid 1 cycle after acceptance; config_out updates 1 cycle after a write.
// Backpressure: recv_rdy drops while the response FIFO is full, independent of send_rdy.
module config_reg_bank #(
  parameter int                      ADDR_SIZE    = 4,
  parameter int                      PAYLOAD_SIZE = 8,
  parameter int                      BASE_ADDR    = 0,
  parameter int                      NUM_REGS     = 4,
  parameter int                      RESP_DEPTH   = 2,
  parameter logic [PAYLOAD_SIZE-1:0] RESET_VAL    = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 recv_val,
  output logic                                 recv_rdy,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]      recv_msg,
  output logic                                 send_val,
  input  logic                                 send_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]      send_msg,
  output logic [NUM_REGS*PAYLOAD_SIZE-1:0]     config_out
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int CW    = $clog2(RESP_DEPTH) + 1;
  // One extra bit so BASE_ADDR+NUM_REGS == 2^ADDR_SIZE does not wrap to zero.
  localparam logic [ADDR_SIZE:0] LO_ADDR = (ADDR_SIZE+1)'(BASE_ADDR);
  localparam logic [ADDR_SIZE:0] HI_ADDR = (ADDR_SIZE+1)'(BASE_ADDR + NUM_REGS);

  logic [PAYLOAD_SIZE-1:0] regs [NUM_REGS];

  logic [ADDR_SIZE-1:0]    req_addr;
  logic                    req_op;
  logic [PAYLOAD_SIZE-1:0] req_payload;
  logic [ADDR_SIZE:0]      addr_ext;
  logic [ADDR_SIZE:0]      idx;
  logic                    hit;
  logic                    accept;
  logic [NUM_REGS-1:0]     sel;
  logic [PAYLOAD_SIZE-1:0] rd_data;
  logic [PAYLOAD_SIZE-1:0] resp_data;
  logic [MSG_W-1:0]        resp_msg;
  logic [MSG_W-1:0]        head_msg;
  logic [CW-1:0]           count;

  assign req_addr    = recv_msg[MSG_W-1:PAYLOAD_SIZE+1];
  assign req_op      = recv_msg[PAYLOAD_SIZE];
  assign req_payload = recv_msg[PAYLOAD_SIZE-1:0];

  assign addr_ext = {1'b0, req_addr};
  assign hit      = (addr_ext >= LO_ADDR) && (addr_ext < HI_ADDR);
  assign idx      = addr_ext - LO_ADDR;

  assign recv_rdy = (count < CW'(RESP_DEPTH));
  assign accept   = recv_val && recv_rdy;

  // Decode the target register and fetch its pre-write contents for reads.
  always_comb begin
    sel     = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit && (idx == (ADDR_SIZE+1)'(i))) begin
        sel[i]  = 1'b1;
        rd_data = regs[i];
      end
    end
  end

  assign resp_data = !hit ? '0 : (req_op ? req_payload : rd_data);
  assign resp_msg  = {req_addr, hit, resp_data};

  // Register writes on an accepted write hit; misses leave the bank untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept && req_op && sel[i]) regs[i] <= req_payload;
      end
    end
  end

  sync_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (accept),
    .wr_dat (resp_msg),
    .rd_en  (send_val && send_rdy),
    .rd_dat (head_msg),
    .count  (count)
  );

  assign send_val = (count != '0);
  // Force zero when empty so stale FIFO storage never appears on the bus.
  assign send_msg = send_val ? head_msg : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign config_out[g*PAYLOAD_SIZE +: PAYLOAD_SIZE] = regs[g];
  end

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed bench for config_reg_bank: default bank plus a BASE_ADDR=12 bank.
// Inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Expected responses are hand-computed constants.
module tb_config_reg_bank;

  logic        clk;
  logic        reset;

  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [12:0] recv_msg, send_msg;
  logic [31:0] config_out;

  logic        hi_recv_val, hi_recv_rdy, hi_send_val, hi_send_rdy;
  logic [12:0] hi_recv_msg, hi_send_msg;
  logic [31:0] hi_config_out;

  int n_chk  = 0;
  int n_pass = 0;

  config_reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
    .recv_msg   (recv_msg),
    .send_val   (send_val),
    .send_rdy   (send_rdy),
    .send_msg   (send_msg),
    .config_out (config_out)
  );

  config_reg_bank #(.BASE_ADDR(12)) dut_hi (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (hi_recv_val),
    .recv_rdy   (hi_recv_rdy),
    .recv_msg   (hi_recv_msg),
    .send_val   (hi_send_val),
    .send_rdy   (hi_send_rdy),
    .send_msg   (hi_send_msg),
    .config_out (hi_config_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic [3:0] a, input logic op, input logic [7:0] d);
    return {a, op, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Single request on the default bank with send_rdy=1; checks the response next cycle.
  task automatic xact(input string tag, input logic [12:0] m, input logic [12:0] exp);
    @(posedge clk); #1;
    recv_val = 1'b1; recv_msg = m; send_rdy = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, recv_rdy, 1);
    @(posedge clk); #1;
    recv_val = 1'b0;
    @(negedge clk);
    chk({tag, "_val"}, send_val, 1);
    chk({tag, "_msg"}, send_msg, exp);
  endtask

  task automatic xact_hi(input string tag, input logic [12:0] m, input logic [12:0] exp);
    @(posedge clk); #1;
    hi_recv_val = 1'b1; hi_recv_msg = m;
    @(posedge clk); #1;
    hi_recv_val = 1'b0;
    @(negedge clk);
    chk({tag, "_val"}, hi_send_val, 1);
    chk({tag, "_msg"}, hi_send_msg, exp);
  endtask

  logic [12:0] sm [8];
  logic [12:0] se [8];

  initial begin
    reset = 1'b0;
    recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
    hi_recv_val = 1'b0; hi_recv_msg = '0; hi_send_rdy = 1'b1;

    // Reset and idle defaults
    @(negedge clk); @(negedge clk);
    chk("rst_rdy", recv_rdy, 1);
    chk("rst_val", send_val, 0);
    chk("rst_msg", send_msg, 0);
    chk("rst_cfg", config_out, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_rdy", recv_rdy, 1);
    chk("idle_val", send_val, 0);
    chk("idle_cfg", config_out, 32'h0);

    // Write hit, read back, untouched read, miss
    xact("wr2", mk(4'h2, 1'b1, 8'hA5), mk(4'h2, 1'b1, 8'hA5));
    chk("wr2_cfg", config_out[23:16], 8'hA5);
    xact("rd2", mk(4'h2, 1'b0, 8'hFF), mk(4'h2, 1'b1, 8'hA5));
    xact("rd3", mk(4'h3, 1'b0, 8'h00), mk(4'h3, 1'b1, 8'h00));
    xact("miss7", mk(4'h7, 1'b1, 8'h55), mk(4'h7, 1'b0, 8'h00));
    @(negedge clk);
    chk("miss7_cfg", config_out, 32'h00A5_0000);
    chk("empty_msg", send_msg, 0);

    // BASE_ADDR=12 boundaries: 11 misses, 15 is idx 3, 12 is idx 0, 0 must not wrap into range
    xact_hi("hi11", mk(4'hB, 1'b1, 8'h11), mk(4'hB, 1'b0, 8'h00));
    xact_hi("hi15", mk(4'hF, 1'b1, 8'h77), mk(4'hF, 1'b1, 8'h77));
    xact_hi("hi12", mk(4'hC, 1'b1, 8'h22), mk(4'hC, 1'b1, 8'h22));
    xact_hi("hi0", mk(4'h0, 1'b1, 8'h99), mk(4'h0, 1'b0, 8'h00));
    @(negedge clk);
    chk("hi_cfg", hi_config_out, 32'h7700_0022);

    // Backpressure: two accepted, third stalls until the first dequeue
    @(posedge clk); #1;
    send_rdy = 1'b0; recv_val = 1'b1; recv_msg = mk(4'h0, 1'b1, 8'h11);
    @(negedge clk);
    chk("bp1_rdy", recv_rdy, 1);
    @(posedge clk); #1 recv_msg = mk(4'h0, 1'b0, 8'h00);
    @(negedge clk);
    chk("bp2_rdy", recv_rdy, 1);
    chk("bp2_head", send_msg, mk(4'h0, 1'b1, 8'h11));
    @(posedge clk); #1 recv_msg = mk(4'h1, 1'b1, 8'h66);
    @(negedge clk);
    chk("bp3_full", recv_rdy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold_rdy", recv_rdy, 0);
    chk("bp_hold_msg", send_msg, mk(4'h0, 1'b1, 8'h11));
    @(posedge clk); #1 send_rdy = 1'b1;
    @(negedge clk);
    chk("bp_full_sr", recv_rdy, 0);
    chk("bp_d1", send_msg, mk(4'h0, 1'b1, 8'h11));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_reopen", recv_rdy, 1);
    chk("bp_d2", send_msg, mk(4'h0, 1'b1, 8'h11));
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    chk("bp_d3_val", send_val, 1);
    chk("bp_d3", send_msg, mk(4'h1, 1'b1, 8'h66));
    chk("bp_cfg", config_out[15:0], 16'h6611);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", send_val, 0);

    // Reset with reg0=0x3C and two queued responses
    xact("set3c", mk(4'h0, 1'b1, 8'h3C), mk(4'h0, 1'b1, 8'h3C));
    @(posedge clk); #1;
    send_rdy = 1'b0; recv_val = 1'b1; recv_msg = mk(4'h1, 1'b0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    chk("pre_rst_val", send_val, 1);
    chk("pre_rst_full", recv_rdy, 0);
    chk("pre_rst_reg0", config_out[7:0], 8'h3C);
    #2 reset = 1'b0;
    #1;
    chk("rst_now_val", send_val, 0);
    chk("rst_now_cfg", config_out, 32'h0);
    chk("rst_now_rdy", recv_rdy, 1);
    @(posedge clk); #1 reset = 1'b1; send_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_val", send_val, 0);
    chk("post_rst_reg0", config_out[7:0], 8'h00);
    @(negedge clk);
    chk("post_rst_val2", send_val, 0);

    // Streaming: back-to-back write then read-after-write pairs
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        sm[i] = mk(4'((i / 2) % 4), 1'b1, 8'(8'h40 + i));
        se[i] = mk(4'((i / 2) % 4), 1'b1, 8'(8'h40 + i));
      end else begin
        sm[i] = mk(4'(((i - 1) / 2) % 4), 1'b0, 8'h00);
        se[i] = mk(4'(((i - 1) / 2) % 4), 1'b1, 8'(8'h40 + i - 1));
      end
    end
    @(posedge clk); #1;
    recv_val = 1'b1; send_rdy = 1'b1; recv_msg = sm[0];
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("str%0d_val", i - 1), send_val, 1);
        chk($sformatf("str%0d_msg", i - 1), send_msg, se[i - 1]);
      end
      if (i < 8) chk($sformatf("str%0d_rdy", i), recv_rdy, 1);
      @(posedge clk); #1;
      if (i < 7) recv_msg = sm[i + 1];
      else recv_val = 1'b0;
    end
    @(negedge clk);
    chk("str_end_val", send_val, 0);
    chk("str_cfg", config_out, 32'h4644_4240);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/config_reg_bank.md
Name: config_reg_bank

Overview:
- Parametrised bank of NUM_REGS configuration registers for the packet-routing interconnect, mapped at consecutive addresses starting at BASE_ADDR.
- Accepts write and read request packets over a val/rdy stream and returns one response packet per accepted request through an internal response FIFO.
- Drives every register's contents continuously to the router/arbiter configuration inputs.

Parameters:
- ADDR_SIZE, 4, address field width in bits.
- PAYLOAD_SIZE, 8, data field and per-register width in bits.
- BASE_ADDR, 0, address of register 0. Legal only if BASE_ADDR+NUM_REGS <= 2^ADDR_SIZE.
- NUM_REGS, 4, number of registers (>=1).
- RESP_DEPTH, 2, response FIFO depth (power of 2, >=2).
- RESET_VAL, 0, value every register takes on reset (PAYLOAD_SIZE bits).

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset: 0 = in reset.
- recv_val, input, 1, request valid.
- recv_rdy, output, 1, request ready.
- recv_msg, input, ADDR_SIZE+PAYLOAD_SIZE+1, request packet {addr, op, payload}. op=1 is write, op=0 is read.
- send_val, output, 1, response valid.
- send_rdy, input, 1, response ready.
- send_msg, output, ADDR_SIZE+PAYLOAD_SIZE+1, response packet {addr, hit, data}.
- config_out, output, NUM_REGS*PAYLOAD_SIZE, register contents. Register i occupies bits [i*PAYLOAD_SIZE +: PAYLOAD_SIZE].

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - All registers = RESET_VAL.
  - FIFO emptied (head=tail=count=0).
  - send_val=0, send_msg=0, recv_rdy=1.
  - config_out = RESET_VAL replicated NUM_REGS times.
- Field slicing: addr = recv_msg[MSB:PAYLOAD_SIZE+1], op = recv_msg[PAYLOAD_SIZE], payload = recv_msg[PAYLOAD_SIZE-1:0].
- Decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR+NUM_REGS).
  - Compare at ADDR_SIZE+1 bits so the upper bound cannot wrap.
  - idx = addr - BASE_ADDR, used only when hit=1.
- Accept: a request is accepted when recv_val && recv_rdy, and only then.
- recv_rdy = (count < RESP_DEPTH). It is combinational from registered count only and does not depend on send_rdy (no full-FIFO bypass).
- Write hit (op=1, hit=1):
  - reg[idx] <= payload at the accepting edge.
  - config_out reflects the new value the cycle after acceptance.
  - Response = {addr, 1, payload}.
- Read hit (op=0, hit=1): response = {addr, 1, reg[idx]}, using the value before the accepting edge. The register is unchanged.
- Miss (hit=0, either op): no register changes. Response = {addr, 0, 0}.
- Response path:
  - The response is enqueued at the accepting edge.
  - send_val=1 from the next cycle (latency 1 cycle when the FIFO was empty).
  - send_msg = FIFO head. send_val = (count != 0).
  - Dequeue on send_val && send_rdy.
  - send_msg holds stable while send_val=1 and send_rdy=0.
  - When the FIFO is empty, send_msg = 0.
- Simultaneous enqueue and dequeue: allowed whenever recv_rdy=1. count stays unchanged; head and tail both advance.
- Full FIFO: count=RESP_DEPTH gives recv_rdy=0, even if send_rdy=1 in the same cycle. recv_rdy rises the cycle after a dequeue.
- Pointers: log2(RESP_DEPTH) bits, wrap modulo RESP_DEPTH. count is log2(RESP_DEPTH)+1 bits.
- Ordering: responses leave strictly in request-acceptance order.
- Reset mid-operation: queued responses are discarded, not sent. Registers return to RESET_VAL immediately on reset assertion.
- No X propagation: every output is driven in every state.

Test Plan:
- Reset, then idle -> recv_rdy=1, send_val=0, config_out=0x00000000 (defaults).
- Write addr=2, data 0xA5 (recv_msg={4'h2,1,8'hA5}), send_rdy=1 -> next cycle send_val=1, send_msg={4'h2,1,8'hA5}; config_out[23:16]=0xA5 from that cycle.
- Read addr=2 after the 0xA5 write -> {4'h2,1,8'hA5}. Read addr=3 untouched -> {4'h3,1,8'h00}.
- Write to addr=7 (miss, BASE_ADDR=0, NUM_REGS=4) -> {4'h7,0,8'h00}, config_out unchanged. Also check BASE_ADDR=12 boundaries: addr 11 misses, addr 15 hits idx 3.
- Backpressure: send_rdy=0, issue 3 requests -> first 2 accepted, recv_rdy=0 on the 3rd. Raise send_rdy -> responses drain in order, the 3rd is accepted one cycle after the first dequeue.
- Reset pulse with 2 queued responses and reg0=0x3C -> send_val=0 immediately; reg0=0x00 and no stale responses after release.
- Streaming: recv_val=send_rdy=1 continuously for 8 requests -> one response per cycle after 1-cycle latency, count never exceeds 1.
